muldiv: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the execute stage of the pipelined core. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO operations from execute, computes over WIDTH+1 cycles, and reports `busy` so decode can stall HI/LO readers. It generalises the single-cycle ALU path with multi-cycle operation, signed/unsigned modes, abort on pipeline flush and a width parameter.

---
 rtl/muldiv.sv | 158 +++++++++++++++
 tb/tb_muldiv.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// ============================================================================
// muldiv : iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO regs
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               neg_q;
    logic               neg_r;
    logic               is_div;

    logic               is_signed;
    logic               rs_neg;
    logic               rt_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_signed = (op == 3'd0) || (op == 3'd2);
    assign rs_neg    = is_signed & rs_data[WIDTH-1];
    assign rt_neg    = is_signed & rt_data[WIDTH-1];
    assign div_zero  = (rt_data == '0);
    assign rs_mag    = rs_neg ? -rs_data : rs_data;
    assign rt_mag    = rt_neg ? -rt_data : rt_data;

    // Shift-add: accumulate into the upper half while the multiplier drains out of the lower half
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

    // Restoring step; diff[WIDTH] is the borrow of the trial subtract
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign diff     = rem_sh - {1'b0, opb};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && kill) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !kill) begin
                            case (op)
                                3'd0, 3'd1: begin
                                    state  <= MUL;
                                    cnt    <= CW'(WIDTH - 1);
                                    opb    <= rs_mag;
                                    acc    <= {{WIDTH{1'b0}}, rt_mag};
                                    neg_q  <= rs_neg ^ rt_neg;
                                    neg_r  <= 1'b0;
                                    is_div <= 1'b0;
                                end
                                3'd2, 3'd3: begin
                                    state  <= DIV;
                                    cnt    <= CW'(WIDTH - 1);
                                    opb    <= rt_mag;
                                    is_div <= 1'b1;
                                    // Zero divisor: raw dividend drains into the remainder, quotient fills with ones
                                    if (div_zero) begin
                                        acc   <= {{WIDTH{1'b0}}, rs_data};
                                        neg_q <= 1'b0;
                                        neg_r <= 1'b0;
                                    end else begin
                                        acc   <= {{WIDTH{1'b0}}, rs_mag};
                                        neg_q <= rs_neg ^ rt_neg;
                                        neg_r <= rs_neg;
                                    end
                                end
                                3'd4:    hi <= rs_data;
                                3'd5:    lo <= rs_data;
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        if (cnt == '0) state <= FIX;
                        else           cnt   <= cnt - CW'(1);
                    end
                    DIV: begin
                        acc <= {rem_next, acc[WIDTH-2:0], q_bit};
                        if (cnt == '0) state <= FIX;
                        else           cnt   <= cnt - CW'(1);
                    end
                    FIX: begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv.sv
// ============================================================================
// tb_muldiv : directed-vector bench for muldiv at WIDTH=32 and WIDTH=8
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst;

    logic        start32, kill32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] rs32, rt32, hi32, lo32;

    logic        start8, kill8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  rs8, rt8, hi8, lo8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32),
        .rs_data(rs32), .rt_data(rt32), .kill(kill32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8),
        .rs_data(rs8), .rt_data(rt8), .kill(kill8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start32 = 1'b1; op32 = o; rs32 = a; rt32 = b;
        tick();
        start32 = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1; op8 = o; rs8 = a; rt8 = b;
        tick();
        start8 = 1'b0;
    endtask

    // Counts busy cycles seen from the current sample until done (bounded)
    task automatic wait_done32(output int cyc);
        cyc = 0;
        while (busy32 && !done32 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (busy8 && !done8 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        issue32(o, a, b);
        wait_done32(cyc);
        check({tag, " busy cycles"}, 64'(cyc), 64'd33);
        check({tag, " done"}, {63'd0, done32}, 64'd1);
        check({tag, " hi"}, {32'd0, hi32}, {32'd0, ehi});
        check({tag, " lo"}, {32'd0, lo32}, {32'd0, elo});
        tick();
        check({tag, " done pulse"}, {63'd0, done32}, 64'd0);
    endtask

    initial begin
        int  cyc;
        logic saw_done;

        rst = 1'b0;
        start32 = 1'b0; kill32 = 1'b0; op32 = '0; rs32 = '0; rt32 = '0;
        start8  = 1'b0; kill8  = 1'b0; op8  = '0; rs8  = '0; rt8  = '0;
        tick();
        tick();
        check("reset busy", {63'd0, busy32}, 64'd0);
        check("reset done", {63'd0, done32}, 64'd0);
        check("reset hi/lo", {hi32, lo32}, 64'd0);
        rst = 1'b1;
        tick();

        run32("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run32("mult -7*6", 3'd0, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        run32("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run32("divu 100/0", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run32("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run32("divu 1000/7", 3'd3, 32'd1000, 32'd7, 32'd6, 32'd142);

        // MTHI then MTLO on consecutive cycles
        issue32(3'd4, 32'h1234_5678, 32'd0);
        check("mthi hi", {32'd0, hi32}, 64'h1234_5678);
        check("mthi busy", {63'd0, busy32}, 64'd0);
        issue32(3'd5, 32'h9ABC_DEF0, 32'd0);
        check("mtlo lo", {32'd0, lo32}, 64'h9ABC_DEF0);
        check("mtlo busy/done", {62'd0, busy32, done32}, 64'd0);

        kill32 = 1'b1;
        issue32(3'd4, 32'hDEAD_BEEF, 32'd0);
        kill32 = 1'b0;
        check("kill drops mthi", {32'd0, hi32}, 64'h1234_5678);

        // Abort a MULT at its tenth busy cycle
        issue32(3'd0, 32'd3, 32'd5);
        repeat (9) tick();
        check("mult still busy", {63'd0, busy32}, 64'd1);
        kill32 = 1'b1;
        tick();
        kill32 = 1'b0;
        check("kill idle", {63'd0, busy32}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done32) saw_done = 1'b1;
            tick();
        end
        check("kill no done", {63'd0, saw_done}, 64'd0);
        check("kill hi/lo kept", {hi32, lo32}, 64'h1234_5678_9ABC_DEF0);

        // Second start while busy is ignored; re-issue on the done cycle
        issue32(3'd1, 32'd3, 32'd4);
        issue32(3'd3, 32'd9, 32'd4);
        wait_done32(cyc);
        check("b2b first busy", 64'(cyc), 64'd32);
        check("b2b first result", {hi32, lo32}, 64'd12);
        issue32(3'd3, 32'd9, 32'd4);
        check("b2b accepted", {62'd0, busy32, done32}, 64'd2);
        wait_done32(cyc);
        check("b2b second busy", 64'(cyc), 64'd33);
        check("b2b second result", {hi32, lo32}, {32'd1, 32'd2});

        // WIDTH=8 instance
        issue8(3'd0, 8'h80, 8'h80);
        wait_done8(cyc);
        check("w8 mult busy", 64'(cyc), 64'd9);
        check("w8 mult done", {63'd0, done8}, 64'd1);
        check("w8 mult hi/lo", {48'd0, hi8, lo8}, 64'h4000);

        issue8(3'd2, 8'd100, 8'd7);
        tick();
        tick();
        check("w8 div busy", {63'd0, busy8}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check("w8 rst busy/done", {62'd0, busy8, done8}, 64'd0);
        check("w8 rst hi/lo", {48'd0, hi8, lo8}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) saw_done = 1'b1;
            tick();
        end
        check("w8 rst quiet", {63'd0, saw_done}, 64'd0);
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
